// File: rtl/cfg_loader.sv
// cfg_loader: configuration controller for the cell array.
// Receives a byte-wide bitstream over a valid/ready handshake and hunts for
// the SYNC_BYTE header. It then assembles 4*NUM_CELLS little-endian payload
// bytes into a shadow register and verifies an XOR checksum byte. On a match
// it commits the shadow atomically to the cells' config buses.
//
// Ports:
//   i_clk          rising-edge clock
//   i_reset        asynchronous active-low reset
//   i_start        one-cycle pulse arming a load (honoured in IDLE/DONE/ERROR)
//   i_cfg_data     bitstream byte
//   i_cfg_valid    i_cfg_data is valid
//   o_cfg_ready    loader accepts a byte this cycle (SYNC/LOAD/CHECK)
//   o_cfg_out      committed config, cell i at [i*CFG_W +: CFG_W]
//   o_fabric_hold  holds the cell fabric in reset while not configured
//   o_busy         load in progress (SYNC/LOAD/CHECK/COMMIT)
//   o_done         sticky, set after a successful commit, cleared by start
//   o_error        sticky, set on checksum mismatch, cleared by start
//
// CFG_W must be in 1..32.

module cfg_loader #(
  parameter int unsigned NUM_CELLS = 4,
  parameter int unsigned CFG_W     = 31,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_start,
  input  logic [7:0]                 i_cfg_data,
  input  logic                       i_cfg_valid,
  output logic                       o_cfg_ready,
  output logic [NUM_CELLS*CFG_W-1:0] o_cfg_out,
  output logic                       o_fabric_hold,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_error
);

  localparam int unsigned NBYTES = 4 * NUM_CELLS;
  localparam int unsigned CNT_W  = $clog2(NBYTES);
  localparam int unsigned CELL_W = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
  localparam int unsigned OUT_W  = NUM_CELLS * CFG_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_LOAD,
    S_CHECK,
    S_COMMIT,
    S_DONE,
    S_ERROR
  } state_t;

  // Registered output decode of a state: {cfg_ready, busy, fabric_hold}.
  function automatic logic [2:0] decode(input state_t s);
    case (s)
      S_SYNC, S_LOAD, S_CHECK: decode = 3'b111;
      S_COMMIT:                decode = 3'b011;
      S_DONE:                  decode = 3'b000;
      default:                 decode = 3'b001;  // IDLE, ERROR
    endcase
  endfunction

  state_t                            r_state;
  logic [2:0]                        r_dec;
  logic [CNT_W-1:0]                  r_cnt;
  logic [7:0]                        r_csum;
  logic [NUM_CELLS-1:0][CFG_W-1:0]   r_shadow;
  logic [OUT_W-1:0]                  r_cfg_out;
  logic                              r_done;
  logic                              r_error;

  logic                              w_accept;
  logic [CELL_W-1:0]                 w_cell;
  logic [1:0]                        w_lane;

  assign w_accept = i_cfg_valid & r_dec[2];
  assign w_cell   = CELL_W'(r_cnt >> 2);
  assign w_lane   = r_cnt[1:0];

  // Main controller: state, handshake decode, assembly, checksum and commit.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= S_IDLE;
      r_dec     <= decode(S_IDLE);
      r_cnt     <= '0;
      r_csum    <= '0;
      r_shadow  <= '0;
      r_cfg_out <= '0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (i_start) begin
            r_state <= S_SYNC;
            r_dec   <= decode(S_SYNC);
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_cnt   <= '0;
            r_csum  <= '0;
          end
        end

        // Discard everything up to the header; the header is not checksummed.
        S_SYNC: begin
          if (w_accept && (i_cfg_data == SYNC_BYTE)) begin
            r_state <= S_LOAD;
            r_dec   <= decode(S_LOAD);
          end
        end

        // Byte k lands in cell k/4, lane k%4. Lane bits at or above CFG_W
        // have no home in the shadow but still feed the checksum.
        S_LOAD: begin
          if (w_accept) begin
            for (int j = 0; j < CFG_W; j++) begin
              if (w_lane == 2'(j / 8)) begin
                r_shadow[w_cell][j] <= i_cfg_data[3'(j % 8)];
              end
            end
            r_csum <= r_csum ^ i_cfg_data;
            if (r_cnt == CNT_W'(NBYTES - 1)) begin
              r_cnt   <= '0;
              r_state <= S_CHECK;
              r_dec   <= decode(S_CHECK);
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end

        // The commit is loaded on the checksum accept edge so the new config
        // is visible during COMMIT; done follows one edge later.
        S_CHECK: begin
          if (w_accept) begin
            if (i_cfg_data == r_csum) begin
              r_cfg_out <= r_shadow;
              r_state   <= S_COMMIT;
              r_dec     <= decode(S_COMMIT);
            end else begin
              r_error <= 1'b1;
              r_state <= S_ERROR;
              r_dec   <= decode(S_ERROR);
            end
          end
        end

        S_COMMIT: begin
          r_done  <= 1'b1;
          r_state <= S_DONE;
          r_dec   <= decode(S_DONE);
        end

        default: begin
          r_state <= S_IDLE;
          r_dec   <= decode(S_IDLE);
        end
      endcase
    end
  end

  assign o_cfg_ready   = r_dec[2];
  assign o_busy        = r_dec[1];
  assign o_fabric_hold = r_dec[0];
  assign o_cfg_out     = r_cfg_out;
  assign o_done        = r_done;
  assign o_error       = r_error;

endmodule

// File: tb/tb_cfg_loader.sv
// Testbench for cfg_loader (NUM_CELLS=2, CFG_W=31). Directed frames are
// driven; each frame's expected terminal response is queued and a separate
// monitor compares it when done or error rises.

module tb_cfg_loader;

  localparam int unsigned NUM_CELLS = 2;
  localparam int unsigned CFG_W     = 31;
  localparam int unsigned OUT_W     = NUM_CELLS * CFG_W;
  localparam logic [7:0]  SYNC      = 8'hA5;

  // cell1=31'h7FFFFFFF, cell0=31'h1
  localparam logic [OUT_W-1:0] OUT_A = 62'h3FFF_FFFF_8000_0001;
  // cell1=31'h1ABCDEF0 (bit 31 of 9ABCDEF0 dropped), cell0=31'h12345678
  localparam logic [OUT_W-1:0] OUT_B = 62'h0D5E_6F78_1234_5678;

  typedef struct packed {
    logic             done;
    logic             error;
    logic             hold;
    logic [OUT_W-1:0] out;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start;
  logic [7:0]       data;
  logic             valid;
  logic             o_cfg_ready;
  logic [OUT_W-1:0] o_cfg_out;
  logic             o_fabric_hold;
  logic             o_busy;
  logic             o_done;
  logic             o_error;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  cfg_loader #(
    .NUM_CELLS (NUM_CELLS),
    .CFG_W     (CFG_W),
    .SYNC_BYTE (SYNC)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst_n),
    .i_start       (start),
    .i_cfg_data    (data),
    .i_cfg_valid   (valid),
    .o_cfg_ready   (o_cfg_ready),
    .o_cfg_out     (o_cfg_out),
    .o_fabric_hold (o_fabric_hold),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_error       (o_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic d, input logic e, input logic h, input logic [OUT_W-1:0] o);
    exp_t x;
    x.done  = d;
    x.error = e;
    x.hold  = h;
    x.out   = o;
    exp_q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present one byte; optional random idle gaps with the data held.
  task automatic send_byte(input logic [7:0] b, input bit bp);
    int t;
    if (bp) begin
      for (int k = 0; k < 3 && $urandom_range(0, 1) == 1; k++) begin
        valid = 1'b0;
        data  = b;
        tick();
      end
    end
    valid = 1'b1;
    data  = b;
    t     = 0;
    while (!o_cfg_ready && t < 20) begin
      tick();
      t++;
    end
    if (t == 20) chk("ready_timeout", 64'(o_cfg_ready), 64'(1));
    tick();
    valid = 1'b0;
  endtask

  // Header, two little-endian words, checksum. Optional start pulse or
  // asynchronous reset before payload byte index start_after / reset_after.
  task automatic send_frame(input logic [31:0] w0, input logic [31:0] w1, input logic [7:0] cs,
                            input bit bp, input int start_after, input int reset_after);
    logic [7:0] pl[8];
    for (int i = 0; i < 4; i++) begin
      pl[i]     = w0[8*i +: 8];
      pl[4 + i] = w1[8*i +: 8];
    end
    send_byte(SYNC, bp);
    for (int i = 0; i < 8; i++) begin
      if (i == reset_after) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_cfg_out", 64'(o_cfg_out), 64'(0));
        chk("rst_mid_ready", 64'(o_cfg_ready), 64'(0));
        chk("rst_mid_hold", 64'(o_fabric_hold), 64'(1));
        chk("rst_mid_busy", 64'(o_busy), 64'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_idle_ready", 64'(o_cfg_ready), 64'(0));
        chk("post_rst_idle_busy", 64'(o_busy), 64'(0));
        chk("post_rst_idle_done", 64'(o_done), 64'(0));
        return;
      end
      if (i == start_after) begin
        pulse_start();
        chk("start_in_load_busy", 64'(o_busy), 64'(1));
        chk("start_in_load_ready", 64'(o_cfg_ready), 64'(1));
      end
      send_byte(pl[i], bp);
    end
    send_byte(cs, bp);
  endtask

  task automatic drain();
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) tick();
    tick();
  endtask

  // Monitor: outputs sampled on the falling edge, index cyc = rising edges so far.
  initial begin
    int               cyc;
    int               acc_edge;
    logic [OUT_W-1:0] prev_out;
    logic             prev_done;
    logic             prev_err;
    exp_t             e;
    cyc       = 0;
    acc_edge  = -100;
    prev_out  = '0;
    prev_done = 1'b0;
    prev_err  = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_out  = o_cfg_out;
        prev_done = o_done;
        prev_err  = o_error;
      end else begin
        if (o_cfg_out !== prev_out)
          chk("cfg_out_changes_on_csum_accept_edge", 64'(cyc), 64'(acc_edge));
        if (o_done && !prev_done) begin
          chk("pending_expect_on_done", 64'(exp_q.size()), 64'(1));
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("done_flag", 64'(o_done), 64'(e.done));
            chk("done_error_flag", 64'(o_error), 64'(e.error));
            chk("done_hold", 64'(o_fabric_hold), 64'(e.hold));
            chk("done_cfg_out", 64'(o_cfg_out), 64'(e.out));
            chk("done_busy", 64'(o_busy), 64'(0));
            // accept edge counts as edge 1, done rises on edge 2
            chk("done_latency_edges", 64'(cyc - acc_edge + 1), 64'(2));
          end
        end
        if (o_error && !prev_err) begin
          chk("pending_expect_on_error", 64'(exp_q.size()), 64'(1));
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("err_done_flag", 64'(o_done), 64'(e.done));
            chk("err_error_flag", 64'(o_error), 64'(e.error));
            chk("err_hold", 64'(o_fabric_hold), 64'(e.hold));
            chk("err_cfg_out", 64'(o_cfg_out), 64'(e.out));
            chk("err_on_accept_edge", 64'(cyc), 64'(acc_edge));
          end
        end
        prev_out  = o_cfg_out;
        prev_done = o_done;
        prev_err  = o_error;
        if (valid && o_cfg_ready) acc_edge = cyc + 1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    start = 1'b0;
    valid = 1'b0;
    data  = 8'h00;
    tick();
    tick();
    chk("reset_cfg_out", 64'(o_cfg_out), 64'(0));
    chk("reset_ready", 64'(o_cfg_ready), 64'(0));
    chk("reset_busy", 64'(o_busy), 64'(0));
    chk("reset_done", 64'(o_done), 64'(0));
    chk("reset_error", 64'(o_error), 64'(0));
    chk("reset_hold", 64'(o_fabric_hold), 64'(1));
    rst_n = 1'b1;
    tick();

    // Basic load
    push_exp(1'b1, 1'b0, 1'b0, OUT_A);
    pulse_start();
    chk("start_enters_sync_ready", 64'(o_cfg_ready), 64'(1));
    send_frame(32'h0000_0001, 32'hFFFF_FFFF, 8'h01, 1'b0, -1, -1);
    drain();

    // Bad checksum: previous config retained, fabric stays held
    push_exp(1'b0, 1'b1, 1'b1, OUT_A);
    pulse_start();
    chk("start_clears_done", 64'(o_done), 64'(0));
    send_frame(32'h1234_5678, 32'h9ABC_DEF0, 8'h5A, 1'b0, -1, -1);
    drain();

    // Reload after error
    push_exp(1'b1, 1'b0, 1'b0, OUT_B);
    pulse_start();
    chk("start_clears_error", 64'(o_error), 64'(0));
    chk("start_sets_hold", 64'(o_fabric_hold), 64'(1));
    send_frame(32'h1234_5678, 32'h9ABC_DEF0, 8'h00, 1'b0, -1, -1);
    drain();

    // Sync hunt with junk prefix and random valid gaps
    push_exp(1'b1, 1'b0, 1'b0, OUT_A);
    pulse_start();
    send_byte(8'h3C, 1'b1);
    send_byte(8'h5A, 1'b1);
    send_frame(32'h0000_0001, 32'hFFFF_FFFF, 8'h01, 1'b1, -1, -1);
    drain();

    // start during LOAD is ignored
    push_exp(1'b1, 1'b0, 1'b0, OUT_B);
    pulse_start();
    send_frame(32'h1234_5678, 32'h9ABC_DEF0, 8'h00, 1'b0, 3, -1);
    drain();

    // Async reset after 5 payload bytes, then a full frame
    pulse_start();
    send_frame(32'h0000_0001, 32'hFFFF_FFFF, 8'h01, 1'b0, -1, 5);
    push_exp(1'b1, 1'b0, 1'b0, OUT_B);
    pulse_start();
    send_frame(32'h1234_5678, 32'h9ABC_DEF0, 8'h00, 1'b0, -1, -1);
    drain();

    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cfg_loader.md
Name: cfg_loader

Overview:
- Configuration controller for the cell array: receives a byte-wide bitstream over a valid/ready handshake and assembles it into a shadow register holding NUM_CELLS configuration words of CFG_W bits.
- Checks the frame with an XOR checksum, then commits the shadow register atomically to the cells' config_bit buses.
- Holds the fabric flip-flops in reset while a load is in progress.
- Sits between the external programming port and the cell array instances.

Parameters:
- NUM_CELLS, 4: number of cells configured per frame.
- CFG_W, 31: config bits per cell, must be ≤ 32.
- SYNC_BYTE, 8'hA5: frame header byte.

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- start, input, 1: one-cycle pulse that arms a load; sampled only in IDLE, DONE or ERROR.
- cfg_data, input, 8: bitstream byte.
- cfg_valid, input, 1: cfg_data is valid.
- cfg_ready, output, 1: loader accepts a byte this cycle.
- cfg_out, output, NUM_CELLS*CFG_W: committed config; cell i uses bits [i*CFG_W +: CFG_W].
- fabric_hold, output, 1: high while a load is in progress; drives the cells' reset.
- busy, output, 1: high in SYNC, LOAD, CHECK and COMMIT.
- done, output, 1: sticky; set when a commit completes, cleared by start.
- error, output, 1: sticky; set on checksum mismatch, cleared by start.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. cfg_out, shadow, byte counter and checksum are all 0. cfg_ready=0, busy=0, done=0, error=0, fabric_hold=1.
- Reset mid-load discards the partial frame and clears cfg_out.
- Handshake: a byte is accepted on a clock edge where cfg_valid & cfg_ready. cfg_ready is a registered state decode: 1 in SYNC, LOAD and CHECK, 0 elsewhere. cfg_data must hold while cfg_valid=1 and cfg_ready=0.
- IDLE: wait for start. On start: go to SYNC, set fabric_hold=1, clear done, error, counter and checksum.
- SYNC: accepted bytes other than SYNC_BYTE are discarded. When SYNC_BYTE is accepted, go to LOAD. The header byte is not included in the checksum.
- LOAD: accepts exactly 4*NUM_CELLS bytes, little-endian, 4 bytes per cell.
  - Byte k goes to cell k/4, byte lane k%4.
  - Bits of the 32-bit group at positions ≥ CFG_W are dropped but still included in the checksum.
  - checksum ^= byte on every accepted byte.
  - The counter wraps to CHECK after byte 4*NUM_CELLS-1.
- CHECK: accept one byte.
  - If it equals the checksum: go to COMMIT.
  - Otherwise: go to ERROR with error=1 and cfg_out unchanged.
- COMMIT: one cycle; cfg_out<=shadow. Next state DONE with done=1, fabric_hold=0, busy=0.
- DONE and ERROR:
  - In DONE, fabric_hold=0 and the fabric runs with the new config.
  - In ERROR, fabric_hold stays 1, so the fabric is not released after a bad frame.
  - A start pulse re-enters SYNC as from IDLE.
- start while busy=1 is ignored. It is never queued.
- Latency: done rises 2 clock edges after the checksum byte's accept edge (CHECK→COMMIT, COMMIT→DONE). cfg_out changes on the first of those edges.
- cfg_out never changes outside COMMIT or reset; no partial configuration is ever visible.
- Throughput: one byte per cycle with cfg_valid held high. A full frame takes 4*NUM_CELLS+2 accepts.

Test Plan:
- Basic load, NUM_CELLS=2:
  - Stimulus: start; stream A5, 01 00 00 00, FF FF FF FF, checksum 01.
  - Response: cfg_out[30:0]=31'h1, cfg_out[61:31]=31'h7FFFFFFF, done=1 exactly 2 cycles after the checksum accept, fabric_hold=0, error=0.
- Bad checksum:
  - Stimulus: same frame with checksum 00.
  - Response: error=1, done=0, cfg_out keeps its previous value, fabric_hold=1.
- Sync hunt and backpressure:
  - Stimulus: prefix 3C 5A before A5; cfg_valid toggled randomly; cfg_data held while not accepted.
  - Response: identical cfg_out to the basic load; junk bytes are not counted.
- start during LOAD:
  - Stimulus: assert start after 3 payload bytes.
  - Response: ignored; the frame completes normally with done=1.
- Async reset mid-LOAD:
  - Stimulus: assert reset=0 between clock edges after 5 payload bytes.
  - Response: immediately cfg_out=0, cfg_ready=0, fabric_hold=1; state IDLE after release.
  - Follow-up: the next full frame loads correctly.
- Reload after ERROR:
  - Stimulus: start, then a valid frame.
  - Response: error clears on start; done=1; cfg_out updated.
